// File: rtl/muldiv_pkg.sv
// Shared RV32M encodings and sequencer state type for the muldiv sequencer
// and the combinational mul/div unit.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_R) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide-by-zero and signed-overflow divisions and produces the
// architecturally defined result for them.
module muldiv_special_case
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_is_special,
  output logic [XLEN-1:0] o_special_result
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  logic w_is_div;
  logic w_div_zero;
  logic w_overflow;

  // funct3[0]=0 selects the signed forms; funct3[1] selects REM over DIV
  always_comb begin
    w_is_div     = i_funct3[2];
    w_div_zero   = w_is_div && (i_rs2 == ZERO);
    w_overflow   = w_is_div && !i_funct3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == ALL_ONES);
    o_is_special = w_div_zero || w_overflow;
    if (w_div_zero) begin
      o_special_result = i_funct3[1] ? i_rs1 : ALL_ONES;
    end else if (w_overflow) begin
      o_special_result = i_funct3[1] ? ZERO : MIN_NEG;
    end else begin
      o_special_result = ZERO;
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multicycle sequencer: holds RV32M operands steady into the combinational
// mul/div unit for a fixed cycle count, then hands the result to writeback.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [6:0]            i_opcode,
  input  logic [6:0]            i_funct7,
  input  logic [2:0]            i_funct3,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic [XLEN-1:0]       o_mult_in1,
  output logic [XLEN-1:0]       o_mult_in2,
  output logic [6:0]            o_opcode,
  output logic [6:0]            o_funct7,
  output logic [2:0]            o_funct3,
  input  logic [XLEN-1:0]       i_unit_result,
  output logic                  o_wb_valid,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]       o_wb_data,
  input  logic                  i_wb_ready
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_load;
  logic                  w_accept;
  logic                  w_count_zero;
  logic                  w_capture;
  logic                  w_is_special;
  logic [XLEN-1:0]       w_special_result;
  logic                  r_special;
  logic [XLEN-1:0]       r_special_result;
  logic [XLEN-1:0]       r_mult_in1;
  logic [XLEN-1:0]       r_mult_in2;
  logic [6:0]            r_opcode;
  logic [6:0]            r_funct7;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;

  // Classified at issue time so the special-case count can be loaded on accept
  muldiv_special_case #(
    .XLEN(XLEN)
  ) u_special (
    .i_funct3        (i_funct3),
    .i_rs1           (i_rs1_data),
    .i_rs2           (i_rs2_data),
    .o_is_special    (w_is_special),
    .o_special_result(w_special_result)
  );

  // Accept qualification and counter reload value
  always_comb begin
    w_accept     = (r_state == IDLE) && i_valid && is_muldiv(i_opcode, i_funct7) && !i_flush;
    w_count_zero = (r_count == CNT_ZERO);
    w_capture    = (r_state == BUSY) && w_count_zero && !i_flush;
    if (w_is_special) begin
      w_count_load = CNT_ZERO;
    end else if (i_funct3[2]) begin
      w_count_load = DIV_LOAD;
    end else begin
      w_count_load = MUL_LOAD;
    end
  end

  // Next-state and stall decode
  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = BUSY;
          o_stall      = 1'b1;
        end else begin
          w_state_next = IDLE;
          o_stall      = 1'b0;
        end
      end
      BUSY: begin
        if (i_flush) begin
          w_state_next = IDLE;
          o_stall      = 1'b0;
        end else if (w_count_zero) begin
          w_state_next = (r_wb_rd != {REG_ADDR_W{1'b0}}) ? DONE : IDLE;
          o_stall      = 1'b1;
        end else begin
          w_state_next = BUSY;
          o_stall      = 1'b1;
        end
      end
      DONE: begin
        w_state_next = i_wb_ready ? IDLE : DONE;
        o_stall      = !i_wb_ready;
      end
      default: begin
        w_state_next = IDLE;
        o_stall      = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Hold-cycle counter; cleared on flush so an aborted op leaves no residue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= CNT_ZERO;
    end else if (w_accept) begin
      r_count <= w_count_load;
    end else if ((r_state == BUSY) && i_flush) begin
      r_count <= CNT_ZERO;
    end else if ((r_state == BUSY) && !w_count_zero) begin
      r_count <= r_count - CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // Operand, field and destination capture on accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mult_in1       <= {XLEN{1'b0}};
      r_mult_in2       <= {XLEN{1'b0}};
      r_opcode         <= 7'b0000000;
      r_funct7         <= 7'b0000000;
      r_funct3         <= 3'b000;
      r_wb_rd          <= {REG_ADDR_W{1'b0}};
      r_special        <= 1'b0;
      r_special_result <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_mult_in1       <= i_rs1_data;
      r_mult_in2       <= i_rs2_data;
      r_opcode         <= i_opcode;
      r_funct7         <= i_funct7;
      r_funct3         <= i_funct3;
      r_wb_rd          <= i_rd_addr;
      r_special        <= w_is_special;
      r_special_result <= w_special_result;
    end else begin
      r_mult_in1       <= r_mult_in1;
      r_mult_in2       <= r_mult_in2;
      r_opcode         <= r_opcode;
      r_funct7         <= r_funct7;
      r_funct3         <= r_funct3;
      r_wb_rd          <= r_wb_rd;
      r_special        <= r_special;
      r_special_result <= r_special_result;
    end
  end

  // Result capture at the last hold cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_data <= {XLEN{1'b0}};
    end else if (w_capture) begin
      r_wb_data <= r_special ? r_special_result : i_unit_result;
    end else begin
      r_wb_data <= r_wb_data;
    end
  end

  assign o_mult_in1 = r_mult_in1;
  assign o_mult_in2 = r_mult_in2;
  assign o_opcode   = r_opcode;
  assign o_funct7   = r_funct7;
  assign o_funct3   = r_funct3;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;
  assign o_wb_valid = (r_state == DONE);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl with a behavioural mul/div unit model.
module tb_muldiv_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [6:0]  i_opcode;
  logic [6:0]  i_funct7;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        i_flush;
  logic        o_stall;
  logic [31:0] o_mult_in1;
  logic [31:0] o_mult_in2;
  logic [6:0]  o_opcode;
  logic [6:0]  o_funct7;
  logic [2:0]  o_funct3;
  logic [31:0] i_unit_result;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        i_wb_ready;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   t0      = 0;

  muldiv_seq_ctrl #(
    .XLEN(32), .MUL_CYCLES(2), .DIV_CYCLES(8), .REG_ADDR_W(5)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_opcode(i_opcode), .i_funct7(i_funct7), .i_funct3(i_funct3),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_flush(i_flush), .o_stall(o_stall),
    .o_mult_in1(o_mult_in1), .o_mult_in2(o_mult_in2),
    .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
    .i_unit_result(i_unit_result), .o_wb_valid(o_wb_valid),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .i_wb_ready(i_wb_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Unit model; special-case operand pairs return a poison value
  always_comb begin
    case (o_funct3)
      3'b000:  i_unit_result = o_mult_in1 * o_mult_in2;
      3'b101:  i_unit_result = (o_mult_in2 != 32'd0) ? o_mult_in1 / o_mult_in2 : 32'hDEAD_BEEF;
      3'b111:  i_unit_result = (o_mult_in2 != 32'd0) ? o_mult_in1 % o_mult_in2 : 32'hDEAD_BEEF;
      default: i_unit_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, o_stall, 1'b0);
    check_eq({tag, "_wb_valid"}, o_wb_valid, 1'b0);
    check_eq({tag, "_in1"}, o_mult_in1, 32'd0);
    check_eq({tag, "_in2"}, o_mult_in2, 32'd0);
    check_eq({tag, "_fields"}, {o_opcode, o_funct7, o_funct3}, 17'd0);
    check_eq({tag, "_wb_rd"}, o_wb_rd, 5'd0);
    check_eq({tag, "_wb_data"}, o_wb_data, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept
  task automatic start_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    i_valid    = 1'b1;
    i_opcode   = 7'b0110011;
    i_funct7   = f7;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    #1;
    check_eq("accept_stall", o_stall, 1'b1);
    t0 = cyc;
    @(negedge i_clk);
    i_valid    = 1'b0;
    i_funct3   = 3'($urandom_range(0, 7));
    i_rs1_data = $urandom();
    i_rs2_data = $urandom();
    i_rd_addr  = 5'($urandom_range(0, 31));
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input int lat);
    sb.push_back('{rd, exp_data, lat});
    start_op(7'b0000001, f3, a, b, rd);
  endtask

  task automatic wait_wb(input string tag);
    int   k;
    exp_t e;
    k = cyc - t0;
    while (!o_wb_valid && k < 40) begin
      check_eq({tag, "_busy_stall"}, o_stall, 1'b1);
      @(negedge i_clk);
      k = cyc - t0;
    end
    if (!o_wb_valid) begin
      check_eq({tag, "_timeout"}, o_wb_valid, 1'b1);
    end else if (sb.size() == 0) begin
      check_eq({tag, "_unexpected_wb"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_latency"}, k, e.lat + 1);
      check_eq({tag, "_rd"}, o_wb_rd, e.rd);
      check_eq({tag, "_data"}, o_wb_data, e.data);
      check_eq({tag, "_done_stall"}, o_stall, !i_wb_ready);
    end
  endtask

  task automatic post_hs(input string tag);
    @(negedge i_clk);
    check_eq({tag, "_after_valid"}, o_wb_valid, 1'b0);
    check_eq({tag, "_after_stall"}, o_stall, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_opcode = 7'd0; i_funct7 = 7'd0; i_funct3 = 3'd0;
    i_rs1_data = 32'd0; i_rs2_data = 32'd0; i_rd_addr = 5'd0; i_flush = 1'b0; i_wb_ready = 1'b1;

    vecs[0] = '{3'b000, 32'd7,          32'd6,          5'd5, 32'd42,         2};
    vecs[1] = '{3'b101, 32'd100,        32'd7,          5'd3, 32'd14,         8};
    vecs[2] = '{3'b111, 32'd100,        32'd7,          5'd3, 32'd2,          8};
    vecs[3] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4, 32'h8000_0000,  1};
    vecs[4] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4, 32'd0,          1};
    vecs[5] = '{3'b101, 32'd9,          32'd0,          5'd6, 32'hFFFF_FFFF,  1};
    vecs[6] = '{3'b110, 32'd5,          32'd0,          5'd7, 32'd5,          1};

    repeat (2) @(negedge i_clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp_data, vecs[i].lat);
      wait_wb($sformatf("vec%0d", i));
      post_hs($sformatf("vec%0d", i));
    end

    // Writeback backpressure for three DONE cycles
    i_wb_ready = 1'b0;
    issue(3'b000, 32'd12, 32'd11, 5'd9, 32'd132, 2);
    wait_wb("bp");
    for (int j = 0; j < 2; j++) begin
      @(negedge i_clk);
      check_eq("bp_hold_valid", o_wb_valid, 1'b1);
      check_eq("bp_hold_rd", o_wb_rd, 5'd9);
      check_eq("bp_hold_data", o_wb_data, 32'd132);
      check_eq("bp_hold_stall", o_stall, 1'b1);
    end
    @(negedge i_clk);
    i_wb_ready = 1'b1;
    #1;
    check_eq("bp_hs_valid", o_wb_valid, 1'b1);
    check_eq("bp_hs_stall", o_stall, 1'b0);
    post_hs("bp");

    // Flush a DIV in cycle 4, then accept a MUL in cycle 5
    start_op(7'b0000001, 3'b100, 32'd50, 32'd5, 5'd4);
    repeat (3) begin
      check_eq("flush_busy_stall", o_stall, 1'b1);
      @(negedge i_clk);
    end
    i_flush = 1'b1;
    #1;
    check_eq("flush_stall", o_stall, 1'b0);
    @(negedge i_clk);
    i_flush = 1'b0;
    check_eq("flush_no_valid", o_wb_valid, 1'b0);
    issue(3'b000, 32'd3, 32'd5, 5'd2, 32'd15, 2);
    wait_wb("after_flush");
    post_hs("after_flush");

    // rd = 0 suppresses writeback
    start_op(7'b0000001, 3'b000, 32'd4, 32'd4, 5'd0);
    repeat (2) begin
      check_eq("rd0_busy_stall", o_stall, 1'b1);
      @(negedge i_clk);
    end
    repeat (4) begin
      check_eq("rd0_stall", o_stall, 1'b0);
      check_eq("rd0_no_valid", o_wb_valid, 1'b0);
      @(negedge i_clk);
    end

    // Non-muldiv instruction is ignored
    i_valid = 1'b1; i_opcode = 7'b0110011; i_funct7 = 7'b0000000; i_funct3 = 3'b000;
    i_rs1_data = 32'd1; i_rs2_data = 32'd2; i_rd_addr = 5'd1;
    repeat (3) begin
      #1;
      check_eq("add_stall", o_stall, 1'b0);
      check_eq("add_no_valid", o_wb_valid, 1'b0);
      @(negedge i_clk);
    end
    i_valid = 1'b0;

    // Reset in cycle 3 of a DIV
    start_op(7'b0000001, 3'b100, 32'd1000, 32'd10, 5'd8);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) begin
      @(negedge i_clk);
      check_eq("midrst_no_valid", o_wb_valid, 1'b0);
    end

    check_eq("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
